// File: rtl/clint_timer.sv
// Core-local interruptor: machine timer (mtime/mtimecmp), software interrupt (msip)
// and a two-flop synchronizer for the external interrupt pin.
module clint_timer #(
  parameter logic [63:0] BASE     = 64'h0000_0000_0200_0000,
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_wdata,
  output logic        resp_ok,
  output logic        resp_err,
  output logic [63:0] resp_rdata,
  input  logic        ext_irq,
  output logic        trint,
  output logic        swint,
  output logic        exint
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);

  localparam logic [63:0] MsipAddr     = BASE + 64'h0000;
  localparam logic [63:0] MtimecmpAddr = BASE + 64'h4000;
  localparam logic [63:0] MtimeAddr    = BASE + 64'hBFF8;

  typedef enum logic [1:0] {
    StIdle,
    StResp,
    StHold
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0] presc_q, presc_d;
  logic [63:0]     mtime_q, mtime_d;
  logic [63:0]     mtimecmp_q, mtimecmp_d;
  logic            msip_q, msip_d;
  logic [63:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [1:0]      sync_q, sync_d;

  logic        accept;
  logic        tick;
  logic        sel_msip, sel_cmp, sel_time, sel_any;
  logic [63:0] wmask;
  logic [63:0] mtime_ticked;

  always_comb begin
    sel_msip = (req_addr == MsipAddr);
    sel_cmp  = (req_addr == MtimecmpAddr);
    sel_time = (req_addr == MtimeAddr);
    sel_any  = sel_msip | sel_cmp | sel_time;
    for (int i = 0; i < 8; i++) begin
      wmask[i*8 +: 8] = {8{req_strobe[i]}};
    end
  end

  // Handshake FSM: HOLD waits for req_valid to drop so a held request is served once.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StResp;
          accept  = 1'b1;
        end
      end
      StResp: state_d = StHold;
      StHold: begin
        if (!req_valid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tick         = (presc_q == CntMax);
    presc_d      = tick ? '0 : presc_q + 1'b1;
    mtime_ticked = tick ? mtime_q + 64'd1 : mtime_q;
    mtime_d      = mtime_ticked;
    mtimecmp_d   = mtimecmp_q;
    msip_d       = msip_q;
    rdata_d      = rdata_q;
    err_d        = err_q;

    if (accept) begin
      err_d   = ~sel_any;
      rdata_d = '0;
      if (!req_write) begin
        if (sel_msip) begin
          rdata_d = {63'd0, msip_q};
        end else if (sel_cmp) begin
          rdata_d = mtimecmp_q;
        end else if (sel_time) begin
          rdata_d = mtime_q;
        end
      end else begin
        if (sel_msip && req_strobe[0]) begin
          msip_d = req_wdata[0];
        end
        if (sel_cmp) begin
          mtimecmp_d = (req_wdata & wmask) | (mtimecmp_q & ~wmask);
        end
        // Unwritten mtime bytes still advance if this is an increment edge.
        if (sel_time) begin
          mtime_d = (req_wdata & wmask) | (mtime_ticked & ~wmask);
        end
      end
    end
  end

  assign sync_d = {sync_q[0], ext_irq};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      sync_q     <= '0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      sync_q     <= sync_d;
    end
  end

  assign resp_ok    = (state_q == StResp);
  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;
  assign trint      = (mtime_q >= mtimecmp_q);
  assign swint      = msip_q;
  assign exint      = sync_q[1];

endmodule

// File: tb/tb_clint_timer.sv
// Directed plus randomized bench for clint_timer; mtime is modelled as an anchor value
// plus elapsed clock edges.
module tb_clint_timer;

  localparam logic [63:0] Base      = 64'h0000_0000_0200_0000;
  localparam logic [63:0] AMsip     = Base + 64'h0000;
  localparam logic [63:0] ACmp      = Base + 64'h4000;
  localparam logic [63:0] ATime     = Base + 64'hBFF8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [63:0] req_addr;
  logic [7:0]  req_strobe;
  logic [63:0] req_wdata;
  logic        resp_ok;
  logic        resp_err;
  logic [63:0] resp_rdata;
  logic        ext_irq;
  logic        trint;
  logic        swint;
  logic        exint;

  clint_timer #(
    .BASE    (Base),
    .PRESCALE(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_strobe(req_strobe),
    .req_wdata (req_wdata),
    .resp_ok   (resp_ok),
    .resp_err  (resp_err),
    .resp_rdata(resp_rdata),
    .ext_irq   (ext_irq),
    .trint     (trint),
    .swint     (swint),
    .exint     (exint)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: mtime after edge k is anchor_val + (k - anchor_k).
  logic [63:0] anchor_val;
  int          anchor_k;
  logic [63:0] cmp_m;
  logic        msip_m;

  function automatic logic [63:0] mt_at(int k);
    return anchor_val + 64'(k - anchor_k);
  endfunction

  function automatic logic [63:0] merge(logic [63:0] old, logic [63:0] nw, logic [7:0] s);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = s[i] ? 8'hFF : 8'h00;
    return (nw & m) | (old & ~m);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_irqs();
    chk("trint", {63'd0, trint}, {63'd0, (mt_at(cyc) >= cmp_m)});
    chk("swint", {63'd0, swint}, {63'd0, msip_m});
  endtask

  task automatic tick();
    @(negedge clk);
    check_irqs();
  endtask

  // Apply the access to the model at accept edge cyc; return the expected response.
  task automatic model_accept(input bit wr, input logic [63:0] addr, input logic [7:0] strb,
                              input logic [63:0] wd, output logic [63:0] erd,
                              output logic eerr);
    int a;
    a    = cyc;
    erd  = '0;
    eerr = 1'b1;
    if (addr == AMsip) begin
      eerr = 1'b0;
      if (!wr) erd = {63'd0, msip_m};
      else if (strb[0]) msip_m = wd[0];
    end else if (addr == ACmp) begin
      eerr = 1'b0;
      if (!wr) erd = cmp_m;
      else cmp_m = merge(cmp_m, wd, strb);
    end else if (addr == ATime) begin
      eerr = 1'b0;
      if (!wr) erd = mt_at(a - 1);
      else begin
        anchor_val = merge(mt_at(a - 1) + 64'd1, wd, strb);
        anchor_k   = a;
      end
    end
  endtask

  // Entered and left just after a negedge with the FSM idle.
  task automatic access(input bit wr, input logic [63:0] addr, input logic [7:0] strb,
                        input logic [63:0] wd, output logic [63:0] rd);
    bit          got;
    logic [63:0] erd;
    logic        eerr;
    got        = 1'b0;
    rd         = 'x;
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_strobe = strb;
    req_wdata  = wd;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (resp_ok === 1'b1) begin
        got = 1'b1;
        model_accept(wr, addr, strb, wd, erd, eerr);
        rd = resp_rdata;
        chk("resp_err", {63'd0, resp_err}, {63'd0, eerr});
        if (!wr) chk("resp_rdata", resp_rdata, erd);
      end
      check_irqs();
    end
    chk("resp_seen", {63'd0, got}, 64'd1);
    req_valid = 1'b0;
    @(negedge clk);
    chk("resp_one_cycle", {63'd0, resp_ok}, 64'd0);
    check_irqs();
    tick();
  endtask

  logic [63:0] rd;
  logic [63:0] addr_tab[8];
  int          pulses;
  int          s;
  int          g;
  bit          got;

  initial begin
    addr_tab = '{AMsip, ACmp, ATime, ATime, Base + 64'h10, Base + 64'h4008,
                 Base + 64'hC000, 64'h0};
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_strobe = '0;
    req_wdata  = '0;
    ext_irq    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_resp_ok", {63'd0, resp_ok}, 64'd0);
    chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_trint", {63'd0, trint}, 64'd0);
    chk("rst_swint", {63'd0, swint}, 64'd0);
    chk("rst_exint", {63'd0, exint}, 64'd0);
    reset      = 1'b1;
    anchor_val = '0;
    anchor_k   = cyc;
    cmp_m      = '1;
    msip_m     = 1'b0;

    // Free-running mtime
    repeat (10) tick();
    access(1'b0, ATime, 8'h00, '0, rd);
    chk("mtime_after_10", rd, 64'd10);
    access(1'b0, ACmp, 8'h00, '0, rd);
    chk("cmp_reset", rd, 64'hFFFF_FFFF_FFFF_FFFF);

    // trint rises when mtime reaches 50, falls when mtimecmp is raised
    access(1'b1, ACmp, 8'hFF, 64'd50, rd);
    g = 0;
    while (mt_at(cyc) < 64'd50 && g < 200) begin
      tick();
      g++;
    end
    chk("trint_at_50", {63'd0, trint}, 64'd1);
    access(1'b1, ACmp, 8'hFF, 64'd1000, rd);
    chk("trint_cleared", {63'd0, trint}, 64'd0);

    // msip
    access(1'b1, AMsip, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, rd);
    chk("swint_set", {63'd0, swint}, 64'd1);
    access(1'b0, AMsip, 8'h00, '0, rd);
    chk("msip_read", rd, 64'd1);
    access(1'b1, AMsip, 8'h01, 64'd0, rd);
    chk("swint_clr", {63'd0, swint}, 64'd0);

    // Wrap and partial write on an increment edge
    access(1'b1, ATime, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE, rd);
    access(1'b0, ATime, 8'h00, '0, rd);
    chk("mtime_wrap", rd, 64'd0);
    access(1'b1, ATime, 8'hFF, 64'h1122_3344_5566_77FD, rd);
    access(1'b1, ATime, 8'h01, 64'h0000_0000_0000_00AA, rd);
    access(1'b0, ATime, 8'h00, '0, rd);
    chk("mtime_partial", rd, 64'h1122_3344_5566_78AC);

    // Unmapped addresses
    access(1'b0, Base + 64'h10, 8'h00, '0, rd);
    chk("unmapped_rdata", rd, 64'd0);
    chk("unmapped_err", {63'd0, resp_err}, 64'd1);
    access(1'b1, Base + 64'h4004, 8'hFF, 64'd7, rd);
    access(1'b0, ACmp, 8'h00, '0, rd);
    chk("cmp_untouched", rd, 64'd1000);

    // Request held for 5 cycles is served once
    s          = cyc;
    pulses     = 0;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = ATime;
    req_strobe = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_ok === 1'b1) begin
        pulses++;
        if (pulses == 1) chk("held_rdata", resp_rdata, mt_at(s));
      end
      check_irqs();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_ok === 1'b1) pulses++;
      check_irqs();
    end
    chk("held_pulses", 64'(pulses), 64'd1);

    // Randomized accesses
    for (int i = 0; i < 30; i++) begin
      logic [63:0] a;
      logic [63:0] wd;
      a  = addr_tab[$urandom_range(0, 7)];
      wd = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) wd[63:32] = '0;
      access(1'($urandom_range(0, 1)), a, 8'($urandom), wd, rd);
    end

    // External interrupt synchronizer
    chk("exint_low", {63'd0, exint}, 64'd0);
    ext_irq = 1'b1;
    @(negedge clk);
    chk("exint_1cyc", {63'd0, exint}, 64'd0);
    @(negedge clk);
    chk("exint_2cyc", {63'd0, exint}, 64'd1);

    // Reset while a response is being presented
    access(1'b1, AMsip, 8'h01, 64'd1, rd);
    access(1'b1, ATime, 8'hFF, 64'h0000_0000_0000_1234, rd);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = ATime;
    req_strobe = 8'h00;
    got        = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (resp_ok === 1'b1) got = 1'b1;
    end
    chk("rr_resp_seen", {63'd0, got}, 64'd1);
    reset     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rr_resp_ok", {63'd0, resp_ok}, 64'd0);
    chk("rr_rdata", resp_rdata, 64'd0);
    chk("rr_err", {63'd0, resp_err}, 64'd0);
    chk("rr_trint", {63'd0, trint}, 64'd0);
    chk("rr_swint", {63'd0, swint}, 64'd0);
    chk("rr_exint", {63'd0, exint}, 64'd0);
    @(negedge clk);
    reset      = 1'b1;
    anchor_val = '0;
    anchor_k   = cyc;
    cmp_m      = '1;
    msip_m     = 1'b0;
    access(1'b0, ACmp, 8'h00, '0, rd);
    chk("rr_cmp", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    access(1'b0, AMsip, 8'h00, '0, rd);
    chk("rr_msip", rd, 64'd0);
    access(1'b0, ATime, 8'h00, '0, rd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
